tlm_hdl2hvl_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one HDL-to-HVL TLM stream FIFO among several HDL-side producers. Each producer presents a valid/ready/data request. The arbiter selects one producer per beat and registers the beat with the producer's index prepended. The registered output drives the valid/ready/dat_i input of a single `tlm_hdl2hvl_fifo`, so the Python side sees one tagged stream. A per-grant burst limit keeps a producer's back-to-back beats contiguous without starving the others.

---
 rtl/tlm_hdl2hvl_rr_arbiter.sv | 128 ++++++++++++
 tb/tb_tlm_hdl2hvl_rr_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlm_hdl2hvl_rr_arbiter.sv
// Round-robin arbiter that merges several valid/ready producers into one tagged,
// registered beat stream for a single HDL-to-HVL TLM FIFO, with a per-grant burst lock.
module tlm_hdl2hvl_rr_arbiter #(
    parameter int  Twidth = 32,
    parameter int  Nreq   = 4,
    parameter int  Burst  = 4,
    localparam int id_w   = (Nreq > 1) ? $clog2(Nreq) : 1,
    localparam int cnt_w  = (Burst > 1) ? $clog2(Burst) : 1
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [Nreq-1:0]          req_valid,
    output logic [Nreq-1:0]          req_ready,
    input  logic [Nreq*Twidth-1:0]   req_dat,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [id_w+Twidth-1:0]   out_dat
);

    logic [id_w-1:0]  ptr_r;
    logic [id_w-1:0]  owner_r;
    logic             locked_r;
    logic [cnt_w-1:0] cnt_r;

    logic [id_w-1:0]  start_s;
    logic [id_w-1:0]  sel_s;
    logic             any_s;
    logic             slot_s;
    logic             accept_s;
    logic             release_s;
    logic             burst_end_s;
    logic [cnt_w-1:0] cnt_base_s;

    function automatic logic [id_w-1:0] next_idx(input logic [id_w-1:0] idx);
        logic [id_w-1:0] res;
        if (int'(idx) >= Nreq - 1) begin
            res = {id_w{1'b0}};
        end else begin
            res = idx + id_w'(1'b1);
        end
        return res;
    endfunction

    function automatic logic [id_w-1:0] wrap_idx(input logic [id_w-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= Nreq) begin
            s = s - Nreq;
        end else begin
            s = s + 0;
        end
        return id_w'(s);
    endfunction

    // Search start: a still-requesting owner keeps the grant, a dropped owner passes to its successor
    always_comb begin
        if (locked_r) begin
            if (req_valid[owner_r]) begin
                start_s = owner_r;
            end else begin
                start_s = next_idx(owner_r);
            end
        end else begin
            start_s = ptr_r;
        end
    end

    // First valid requester in wrapping order from start_s
    always_comb begin
        sel_s = start_s;
        any_s = 1'b0;
        for (int k = 0; k < Nreq; k++) begin
            sel_s = (req_valid[wrap_idx(start_s, k)] && !any_s) ? wrap_idx(start_s, k) : sel_s;
            any_s = any_s | req_valid[wrap_idx(start_s, k)];
        end
    end

    // Handshake qualifiers; a released lock restarts the beat count before this cycle's accept
    always_comb begin
        slot_s      = ~out_valid | out_ready;
        accept_s    = any_s & slot_s;
        release_s   = slot_s & locked_r & ~req_valid[owner_r];
        cnt_base_s  = release_s ? {cnt_w{1'b0}} : cnt_r;
        burst_end_s = ((int'(cnt_base_s) + 32'sd1) == Burst);
    end

    // One-hot ready toward the selected requester
    always_comb begin
        req_ready = {Nreq{1'b0}};
        for (int i = 0; i < Nreq; i++) begin
            req_ready[i] = reset_n & accept_s & (sel_s == id_w'(i));
        end
    end

    // Arbitration state and output beat register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr_r     <= {id_w{1'b0}};
            owner_r   <= {id_w{1'b0}};
            locked_r  <= 1'b0;
            cnt_r     <= {cnt_w{1'b0}};
            out_valid <= 1'b0;
            out_dat   <= {(id_w+Twidth){1'b0}};
        end else begin
            if (release_s) begin
                locked_r <= 1'b0;
                cnt_r    <= {cnt_w{1'b0}};
                ptr_r    <= next_idx(owner_r);
            end
            if (accept_s) begin
                out_valid <= 1'b1;
                out_dat   <= {sel_s, req_dat[int'(sel_s)*Twidth +: Twidth]};
                if (burst_end_s) begin
                    locked_r <= 1'b0;
                    cnt_r    <= {cnt_w{1'b0}};
                    ptr_r    <= next_idx(sel_s);
                end else begin
                    locked_r <= 1'b1;
                    owner_r  <= sel_s;
                    cnt_r    <= cnt_base_s + cnt_w'(1'b1);
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tlm_hdl2hvl_rr_arbiter.sv
// Bench for tlm_hdl2hvl_rr_arbiter: vector table, directed corner sequences and
// randomized traffic checked against a grant-level reference model.
module tb_tlm_hdl2hvl_rr_arbiter;

    localparam int N = 4;
    localparam int B = 4;

    logic         clock;
    logic         reset_n;
    logic [3:0]   valid;
    logic [3:0]   rdy;
    logic [127:0] dat;
    logic         ov;
    logic         ordy;
    logic [33:0]  od;

    logic [3:0]   v1;
    logic [3:0]   rdy1;
    logic [127:0] d1;
    logic         ov1;
    logic         ordy1;
    logic [33:0]  od1;

    int n_cmp = 0;
    int n_bad = 0;

    tlm_hdl2hvl_rr_arbiter #(.Twidth(32), .Nreq(N), .Burst(B)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(valid), .req_ready(rdy), .req_dat(dat),
        .out_valid(ov), .out_ready(ordy), .out_dat(od)
    );

    tlm_hdl2hvl_rr_arbiter #(.Twidth(32), .Nreq(N), .Burst(1)) dut1 (
        .clock(clock), .reset_n(reset_n),
        .req_valid(v1), .req_ready(rdy1), .req_dat(d1),
        .out_valid(ov1), .out_ready(ordy1), .out_dat(od1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: who currently holds a burst grant, how many beats it took,
    // where the next fresh search begins, and the beat waiting downstream.
    int          m_owner;
    int          m_taken;
    int          m_prio;
    bit          m_ov;
    logic [33:0] m_od;

    typedef struct {
        logic [3:0] valid;
        logic       ordy;
        logic [3:0] exp_rdy;
        logic       exp_ov;
        logic [1:0] exp_id;
    } vec_t;
    vec_t tq[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_owner = -1;
        m_taken = 0;
        m_prio  = 0;
        m_ov    = 1'b0;
        m_od    = 34'h0;
    endtask

    function automatic int m_pick();
        int start;
        int g;
        g = -1;
        if (m_owner >= 0 && valid[m_owner]) begin
            g = m_owner;
        end else begin
            start = (m_owner >= 0) ? (m_owner + 1) % N : m_prio;
            for (int k = N - 1; k >= 0; k--) begin
                if (valid[(start + k) % N]) g = (start + k) % N;
            end
        end
        return g;
    endfunction

    function automatic logic [3:0] m_ready();
        logic [3:0] r;
        int g;
        r = 4'b0000;
        g = m_pick();
        if (reset_n && (!m_ov || ordy) && g >= 0) r = 4'b0001 << g;
        return r;
    endfunction

    task automatic m_step();
        int g;
        int taken;
        bit slot;
        bit rel;
        if (!reset_n) begin
            m_reset();
        end else begin
            slot  = !m_ov || ordy;
            g     = m_pick();
            rel   = slot && (m_owner >= 0) && !valid[m_owner];
            taken = rel ? 0 : m_taken;
            if (rel) begin
                m_prio  = (m_owner + 1) % N;
                m_owner = -1;
                m_taken = 0;
            end
            if (slot && g >= 0) begin
                m_od = {2'(g), dat[g*32 +: 32]};
                m_ov = 1'b1;
                if (taken + 1 == B) begin
                    m_owner = -1;
                    m_taken = 0;
                    m_prio  = (g + 1) % N;
                end else begin
                    m_owner = g;
                    m_taken = taken + 1;
                end
            end else if (m_ov && ordy) begin
                m_ov = 1'b0;
            end
        end
    endtask

    task automatic at_neg();
        @(negedge clock);
        check("model_ready", 64'(rdy), 64'(m_ready()));
        check("model_out_valid", 64'(ov), 64'(m_ov));
        check("model_out_dat", 64'(od), 64'(m_od));
    endtask

    task automatic finish_cycle();
        m_step();
        @(posedge clock);
        #1;
    endtask

    task automatic add_vec(input logic [3:0] v, input logic [3:0] er, input logic eov, input logic [1:0] eid);
        vec_t e;
        e.valid   = v;
        e.ordy    = 1'b1;
        e.exp_rdy = er;
        e.exp_ov  = eov;
        e.exp_id  = eid;
        tq.push_back(e);
    endtask

    logic [3:0] last_rdy;

    initial begin
        reset_n = 1'b0;
        valid   = 4'hF;
        ordy    = 1'b1;
        v1      = 4'h0;
        ordy1   = 1'b1;
        for (int i = 0; i < N; i++) dat[i*32 +: 32] = 32'hA5A5_0000 + 32'(i);
        d1 = dat;
        m_reset();

        // Burst lock over all four requesters, then requester 1 drops early
        for (int r = 0; r < 20; r++) begin
            add_vec(4'hF, 4'b0001 << ((r / 4) % 4), (r > 0), 2'(((r - 1) / 4) % 4));
        end
        add_vec(4'b1110, 4'b0010, 1'b1, 2'd0);
        add_vec(4'b1110, 4'b0010, 1'b1, 2'd1);
        add_vec(4'b1100, 4'b0100, 1'b1, 2'd1);
        add_vec(4'b1100, 4'b0100, 1'b1, 2'd2);
        add_vec(4'b1100, 4'b0100, 1'b1, 2'd2);
        add_vec(4'b1100, 4'b0100, 1'b1, 2'd2);
        add_vec(4'b1100, 4'b1000, 1'b1, 2'd2);
        add_vec(4'b1100, 4'b1000, 1'b1, 2'd3);

        for (int c = 0; c < 2; c++) begin
            at_neg();
            check("reset_ready", 64'(rdy), 64'h0);
            check("reset_out_valid", 64'(ov), 64'h0);
            finish_cycle();
        end
        reset_n = 1'b1;

        for (int r = 0; r < tq.size(); r++) begin
            valid = tq[r].valid;
            ordy  = tq[r].ordy;
            at_neg();
            check("tbl_ready", 64'(rdy), 64'(tq[r].exp_rdy));
            check("tbl_out_valid", 64'(ov), 64'(tq[r].exp_ov));
            if (tq[r].exp_ov) begin
                check("tbl_out_dat", 64'(od), 64'({tq[r].exp_id, 32'hA5A5_0000 + 32'(tq[r].exp_id)}));
            end
            finish_cycle();
        end

        // Backpressure with requester 2 holding a beat in the output register
        valid = 4'b0100;
        ordy  = 1'b1;
        at_neg();
        finish_cycle();
        ordy = 1'b0;
        for (int c = 0; c < 5; c++) begin
            at_neg();
            check("bp_out_valid", 64'(ov), 64'h1);
            check("bp_out_dat", 64'(od), 64'({2'd2, 32'hA5A5_0002}));
            check("bp_ready", 64'(rdy), 64'h0);
            finish_cycle();
        end
        ordy = 1'b1;
        for (int c = 0; c < 3; c++) begin
            at_neg();
            check("bp_resume_ready", 64'(rdy), 64'(4'b0100));
            check("bp_resume_valid", 64'(ov), 64'h1);
            finish_cycle();
        end

        // Clean reset pulse, two beats from requester 0, then asynchronous reset mid-burst
        valid   = 4'hF;
        reset_n = 1'b0;
        m_reset();
        at_neg();
        finish_cycle();
        reset_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            at_neg();
            finish_cycle();
        end
        #1;
        reset_n = 1'b0;
        #1;
        check("async_out_valid", 64'(ov), 64'h0);
        check("async_ready", 64'(rdy), 64'h0);
        m_reset();
        reset_n = 1'b1;
        #1;
        for (int c = 0; c < 6; c++) begin
            at_neg();
            if (c < 4) check("restart_ready", 64'(rdy), 64'(4'b0001));
            finish_cycle();
        end

        // Burst=1 instance: plain round-robin between requesters 0 and 3
        v1 = 4'b1001;
        for (int k = 0; k < 8; k++) begin
            at_neg();
            check("rr1_ready", 64'(rdy1), (k % 2 == 0) ? 64'(4'b0001) : 64'(4'b1000));
            if (k >= 1) begin
                check("rr1_out_valid", 64'(ov1), 64'h1);
                check("rr1_out_dat", 64'(od1), (k % 2 == 1) ? 64'({2'd0, 32'hA5A5_0000}) : 64'({2'd3, 32'hA5A5_0003}));
            end
            finish_cycle();
        end
        v1 = 4'h0;

        // Randomized traffic; payloads only change once a beat was taken or valid was low
        last_rdy = 4'hF;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!valid[i] || last_rdy[i]) begin
                    valid[i] = ($urandom_range(0, 2) != 0);
                    dat[i*32 +: 32] = $urandom;
                end else if ($urandom_range(0, 7) == 0) begin
                    valid[i] = 1'b0;
                end
            end
            ordy = ($urandom_range(0, 3) != 0);
            at_neg();
            last_rdy = m_ready();
            finish_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
